// File: rtl/mem_arb_pkg.sv
// Shared types for the BRAM port arbiter: FSM states, owner IDs and
// the legal BRAM read-latency range.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_IF  = 2'd0,
        OWN_DM  = 2'd1,
        OWN_DBG = 2'd2
    } owner_t;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;
    localparam int STARVE_W   = 8;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner select for the BRAM port (dm > if > dbg) with a starvation
// counter that lets a long-waiting debug request jump the queue.
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       arb_en,
    input  logic       if_req,
    input  logic       dm_req,
    input  logic       dbg_req,
    output logic       win_vld,
    output logic [1:0] win_id
);
    localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

    logic [STARVE_W-1:0] starve_cnt;
    logic                dbg_force;

    assign dbg_force = dbg_req && (starve_cnt == STARVE_LIM);

    always_comb begin
        win_vld = arb_en && (if_req || dm_req || dbg_req);
        win_id  = OWN_IF;
        if (dbg_force)    win_id = OWN_DBG;
        else if (dm_req)  win_id = OWN_DM;
        else if (if_req)  win_id = OWN_IF;
        else if (dbg_req) win_id = OWN_DBG;
    end

    // Counts only arbitrations debug actually lost; a dropped request forgets its history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (!dbg_req) begin
            starve_cnt <= '0;
        end else if (win_vld) begin
            if (win_id == OWN_DBG)
                starve_cnt <= '0;
            else if (starve_cnt != STARVE_LIM)
                starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port instruction/data BRAM between fetch, data access
// and the debug readout, one access at a time through IDLE/ACCESS/WAIT.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    input  logic              dbg_req,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);
    localparam int LAT_W = $clog2(RD_LAT_MAX + 1);

    arb_state_t        state;
    owner_t            owner;
    logic [LAT_W-1:0]  lat_cnt;
    logic              arb_en;
    logic              win_vld;
    logic [1:0]        win_id;
    owner_t            win_own;
    logic [ADDR_W-1:0] sel_addr;
    logic              sel_we;

    assign arb_en  = (state == IDLE);
    assign win_own = owner_t'(win_id);
    assign busy    = (state != IDLE);

    mem_arb_pick #(.STARVE_MAX(STARVE_MAX)) u_pick (
        .clk     (clk),
        .rst_n   (rst_n),
        .arb_en  (arb_en),
        .if_req  (if_req),
        .dm_req  (dm_req),
        .dbg_req (dbg_req),
        .win_vld (win_vld),
        .win_id  (win_id)
    );

    always_comb begin
        sel_addr = if_addr;
        sel_we   = 1'b0;
        case (win_own)
            OWN_DM:  begin sel_addr = dm_addr; sel_we = dm_we; end
            OWN_DBG: sel_addr = dbg_addr;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= OWN_IF;
            lat_cnt    <= '0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_gnt     <= 1'b0;
            dm_gnt     <= 1'b0;
            dbg_gnt    <= 1'b0;
            if_rvalid  <= 1'b0;
            dm_rvalid  <= 1'b0;
            dbg_rvalid <= 1'b0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
            dbg_rdata  <= '0;
        end else begin
            if_gnt     <= 1'b0;
            dm_gnt     <= 1'b0;
            dbg_gnt    <= 1'b0;
            if_rvalid  <= 1'b0;
            dm_rvalid  <= 1'b0;
            dbg_rvalid <= 1'b0;
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        state     <= ACCESS;
                        owner     <= win_own;
                        mem_en    <= 1'b1;
                        mem_we    <= sel_we;
                        mem_addr  <= sel_addr;
                        mem_wdata <= sel_we ? dm_wdata : '0;
                        if_gnt    <= (win_own == OWN_IF);
                        dm_gnt    <= (win_own == OWN_DM);
                        dbg_gnt   <= (win_own == OWN_DBG);
                    end
                end
                ACCESS: begin
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                    if (mem_we) begin
                        state <= IDLE;
                    end else begin
                        state   <= WAIT;
                        lat_cnt <= LAT_W'(RD_LAT);
                    end
                end
                WAIT: begin
                    // Last wait cycle is the one where BRAM data is on mem_rdata.
                    if (lat_cnt == LAT_W'(1)) begin
                        state <= IDLE;
                        case (owner)
                            OWN_DM:  begin dm_rvalid  <= 1'b1; dm_rdata  <= mem_rdata; end
                            OWN_DBG: begin dbg_rvalid <= 1'b1; dbg_rdata <= mem_rdata; end
                            default: begin if_rvalid  <= 1'b1; if_rdata  <= mem_rdata; end
                        endcase
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: two arbiters (RD_LAT 1 and 3) each with a BRAM model;
// a transaction-level reference model predicts grants and read returns.
module tb_mem_port_arbiter;
    localparam int N    = 2;
    localparam int SMAX = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req      [N][3];
    logic [15:0] addr     [N][3];
    logic        dm_we    [N];
    logic [31:0] dm_wdata [N];
    logic        gnt      [N][3];
    logic        rvalid   [N][3];
    logic [31:0] rdata    [N][3];
    logic        mem_en   [N];
    logic        mem_we   [N];
    logic        busy     [N];
    logic [15:0] mem_addr [N];
    logic [31:0] mem_wdata[N];
    logic [31:0] mem_rdata[N];

    typedef struct { int cyc; logic we; logic [15:0] addr; logic [31:0] wdata; } gnt_exp_t;
    typedef struct { int cyc; logic [31:0] data; } rv_exp_t;

    gnt_exp_t    gq [N][3][$];
    rv_exp_t     rq [N][3][$];
    logic [31:0] ref_mem [N][65536];
    bit          ref_wr  [N][65536];
    int          next_arb[N], busy_end[N], starve[N];
    logic [31:0] last_rd [N][3];
    int          cyc = 0;
    int          errors = 0, checks = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] boot_word(input logic [15:0] a);
        if (a == 16'h0010) return 32'h2008_0005;
        return {a, ~a} ^ 32'h5A5A_0000;
    endfunction

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst=%0d cyc=%0d got=%h expected=%h", nm, inst, cyc, act, exp);
        end
    endtask

    function automatic logic outs_nonzero(input int i);
        logic nz;
        nz = busy[i] | mem_en[i] | mem_we[i] | (|mem_addr[i]) | (|mem_wdata[i]);
        for (int p = 0; p < 3; p++) nz = nz | gnt[i][p] | rvalid[i][p] | (|rdata[i][p]);
        return nz;
    endfunction

    for (genvar g = 0; g < N; g++) begin : g_inst
        localparam int LAT = (g == 0) ? 1 : 3;
        logic [31:0] bram    [65536];
        bit          written [65536];
        logic [31:0] pipe    [4];

        initial forever begin
            @(posedge clk);
            pipe[0] <= written[mem_addr[g]] ? bram[mem_addr[g]] : boot_word(mem_addr[g]);
            pipe[1] <= pipe[0];
            pipe[2] <= pipe[1];
            pipe[3] <= pipe[2];
            if (mem_en[g] && mem_we[g]) begin
                bram[mem_addr[g]]    = mem_wdata[g];
                written[mem_addr[g]] = 1'b1;
            end
        end
        assign mem_rdata[g] = pipe[LAT-1];

        mem_port_arbiter #(.ADDR_W(16), .DATA_W(32), .RD_LAT(LAT), .STARVE_MAX(SMAX)) u_dut (
            .clk(clk), .rst_n(rst_n),
            .if_req(req[g][0]), .if_addr(addr[g][0]), .if_gnt(gnt[g][0]),
            .if_rvalid(rvalid[g][0]), .if_rdata(rdata[g][0]),
            .dm_req(req[g][1]), .dm_we(dm_we[g]), .dm_addr(addr[g][1]), .dm_wdata(dm_wdata[g]),
            .dm_gnt(gnt[g][1]), .dm_rvalid(rvalid[g][1]), .dm_rdata(rdata[g][1]),
            .dbg_req(req[g][2]), .dbg_addr(addr[g][2]), .dbg_gnt(gnt[g][2]),
            .dbg_rvalid(rvalid[g][2]), .dbg_rdata(rdata[g][2]),
            .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
            .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g]), .busy(busy[g])
        );
    end

    // Reference model: one arbitration per free edge, occupancy from latency arithmetic.
    int          m_w;
    logic        m_we;
    logic [15:0] m_a;
    logic [31:0] m_d;
    initial forever begin
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            if (!rst_n) begin
                for (int p = 0; p < 3; p++) begin gq[i][p].delete(); rq[i][p].delete(); end
                next_arb[i] = 0; busy_end[i] = 0; starve[i] = 0;
            end else begin
                if (cyc >= next_arb[i] && (req[i][0] || req[i][1] || req[i][2])) begin
                    if (req[i][2] && starve[i] == SMAX) m_w = 2;
                    else if (req[i][1])                 m_w = 1;
                    else if (req[i][0])                 m_w = 0;
                    else                                m_w = 2;
                    m_we = (m_w == 1) && dm_we[i];
                    m_a  = addr[i][m_w];
                    gq[i][m_w].push_back('{cyc + 1, m_we, m_a, dm_wdata[i]});
                    if (m_we) begin
                        ref_mem[i][m_a] = dm_wdata[i];
                        ref_wr[i][m_a]  = 1'b1;
                        next_arb[i]     = cyc + 2;
                    end else begin
                        m_d = ref_wr[i][m_a] ? ref_mem[i][m_a] : boot_word(m_a);
                        rq[i][m_w].push_back('{cyc + lat_of(i) + 2, m_d});
                        next_arb[i] = cyc + lat_of(i) + 2;
                    end
                    busy_end[i] = next_arb[i];
                    if (req[i][2]) starve[i] = (m_w == 2) ? 0 : ((starve[i] < SMAX) ? starve[i] + 1 : SMAX);
                end
                if (!req[i][2]) starve[i] = 0;
            end
        end
        cyc++;
    end

    // Monitor: compares every output each cycle against what the model scheduled.
    gnt_exp_t ge;
    rv_exp_t  re;
    logic     eg, er, exp_en, exp_we;
    initial forever begin
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (!rst_n) begin
                chk("reset_outputs", i, 32'(outs_nonzero(i)), 32'd0);
                for (int p = 0; p < 3; p++) last_rd[i][p] = '0;
            end else begin
                exp_en = 1'b0; exp_we = 1'b0;
                for (int p = 0; p < 3; p++) begin
                    eg = (gq[i][p].size() > 0) && (gq[i][p][0].cyc == cyc);
                    chk($sformatf("gnt%0d", p), i, 32'(gnt[i][p]), 32'(eg));
                    if (eg) begin
                        ge = gq[i][p].pop_front();
                        exp_en = 1'b1; exp_we = ge.we;
                        chk("mem_addr", i, 32'(mem_addr[i]), 32'(ge.addr));
                        if (ge.we) chk("mem_wdata", i, mem_wdata[i], ge.wdata);
                    end
                    er = (rq[i][p].size() > 0) && (rq[i][p][0].cyc == cyc);
                    chk($sformatf("rvalid%0d", p), i, 32'(rvalid[i][p]), 32'(er));
                    if (er) begin
                        re = rq[i][p].pop_front();
                        last_rd[i][p] = re.data;
                    end
                    chk($sformatf("rdata%0d", p), i, rdata[i][p], last_rd[i][p]);
                end
                chk("mem_en", i, 32'(mem_en[i]), 32'(exp_en));
                chk("mem_we", i, 32'(mem_we[i]), 32'(exp_we));
                chk("busy", i, 32'(busy[i]), 32'(cyc < busy_end[i]));
            end
        end
    end

    task automatic issue(input int i, input int p, input logic [15:0] a, input logic we, input logic [31:0] wd);
        req[i][p]  = 1'b1;
        addr[i][p] = a;
        if (p == 1) begin dm_we[i] = we; dm_wdata[i] = wd; end
    endtask

    task automatic wait_gnt(input int i, input int p, output int at);
        int n = 0;
        do begin @(negedge clk); n++; end while (!gnt[i][p] && n < 200);
        chk("gnt_seen", i, 32'(gnt[i][p]), 32'd1);
        at = cyc;
    endtask

    task automatic wait_rv(input int i, input int p, output int at);
        int n = 0;
        do begin @(negedge clk); n++; end while (!rvalid[i][p] && n < 50);
        chk("rvalid_seen", i, 32'(rvalid[i][p]), 32'd1);
        at = cyc;
    endtask

    task automatic rand_req(input int i, input int p, input int n);
        int t;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            issue(i, p, 16'($urandom_range(0, 31)), (p == 1) && ($urandom_range(0, 1) == 1), $urandom);
            wait_gnt(i, p, t);
            req[i][p] = 1'b0;
            if (p == 1) dm_we[i] = 1'($urandom_range(0, 1));
        end
    endtask

    int t0, t1, t2, t3, t_if, t_dm, t_dbg, others, got, seen;
    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) begin
            dm_we[i] = 1'b0; dm_wdata[i] = '0;
            for (int p = 0; p < 3; p++) begin req[i][p] = 1'b0; addr[i][p] = '0; end
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single fetch read at RD_LAT=1
        issue(0, 0, 16'h0010, 1'b0, '0);
        wait_gnt(0, 0, t0);
        req[0][0] = 1'b0;
        wait_rv(0, 0, t1);
        chk("fetch_latency", 0, t1 - t0, 2);
        chk("fetch_data", 0, rdata[0][0], 32'h2008_0005);
        repeat (3) @(negedge clk);

        // Data write then read back
        issue(0, 1, 16'h0100, 1'b1, 32'hDEAD_BEEF);
        wait_gnt(0, 1, t0);
        chk("write_mem_we", 0, 32'(mem_we[0]), 32'd1);
        issue(0, 1, 16'h0100, 1'b0, 32'h0);
        wait_gnt(0, 1, t1);
        chk("write_occupancy", 0, t1 - t0, 2);
        req[0][1] = 1'b0;
        wait_rv(0, 1, t2);
        chk("readback_data", 0, rdata[0][1], 32'hDEAD_BEEF);
        repeat (3) @(negedge clk);

        // Simultaneous requests on all three ports
        issue(0, 0, 16'h0020, 1'b0, '0);
        issue(0, 1, 16'h0021, 1'b0, '0);
        issue(0, 2, 16'h0022, 1'b0, '0);
        fork
            begin wait_gnt(0, 0, t_if);  req[0][0] = 1'b0; end
            begin wait_gnt(0, 1, t_dm);  req[0][1] = 1'b0; end
            begin wait_gnt(0, 2, t_dbg); req[0][2] = 1'b0; end
        join
        chk("simul_order", 0, 32'(t_dm < t_if && t_if < t_dbg), 32'd1);
        chk("simul_spacing", 0, t_dbg - t_if, 3);
        repeat (6) @(negedge clk);

        // Debug starvation: dbg must win the 9th arbitration, twice in a row
        issue(0, 0, 16'h0030, 1'b0, '0);
        issue(0, 1, 16'h0031, 1'b0, '0);
        issue(0, 2, 16'd6303, 1'b0, '0);
        for (int r = 0; r < 2; r++) begin
            others = 0; got = 0;
            for (int c = 0; c < 200 && got == 0; c++) begin
                @(negedge clk);
                if (gnt[0][2]) got = 1;
                else if (gnt[0][0] || gnt[0][1]) others++;
            end
            chk("starve_dbg_won", 0, got, 1);
            chk("starve_losses", 0, others, SMAX);
        end
        req[0][0] = 1'b0; req[0][1] = 1'b0; req[0][2] = 1'b0;
        repeat (6) @(negedge clk);

        // RD_LAT=3 back-to-back debug reads
        issue(1, 2, 16'd6302, 1'b0, '0);
        wait_gnt(1, 2, t0);
        addr[1][2] = 16'd6303;
        wait_rv(1, 2, t1);
        chk("lat3_rv1", 1, t1 - t0, 4);
        chk("lat3_data1", 1, rdata[1][2], boot_word(16'd6302));
        wait_gnt(1, 2, t2);
        req[1][2] = 1'b0;
        chk("lat3_gnt_spacing", 1, t2 - t0, 5);
        wait_rv(1, 2, t3);
        chk("lat3_rv2", 1, t3 - t2, 4);
        chk("lat3_data2", 1, rdata[1][2], boot_word(16'd6303));
        repeat (4) @(negedge clk);

        // Randomized traffic on both arbiters
        fork
            rand_req(0, 0, 40); rand_req(0, 1, 40); rand_req(0, 2, 40);
            rand_req(1, 0, 40); rand_req(1, 1, 40); rand_req(1, 2, 40);
        join
        repeat (10) @(negedge clk);
        for (int i = 0; i < N; i++)
            for (int p = 0; p < 3; p++)
                chk("drained", i, gq[i][p].size() + rq[i][p].size(), 0);

        // Reset in the WAIT cycle of a debug read
        issue(0, 2, 16'd6302, 1'b0, '0);
        wait_gnt(0, 2, t0);
        req[0][2] = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("reset_now_inst0", 0, 32'(outs_nonzero(0)), 32'd0);
        chk("reset_now_inst1", 1, 32'(outs_nonzero(1)), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (rvalid[0][2]) seen++;
        end
        chk("no_rvalid_after_reset", 0, seen, 0);
        chk("busy_after_reset", 0, 32'(busy[0]), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d expected completion before 50000 cycles", cyc);
        $fatal(1, "watchdog");
    end

endmodule
